// File: rtl/midi_msg_decoder.sv
// Channel-voice message assembler sitting behind the MIDI UART, with a one-entry valid/ready output slot.
// Define MIDI_ACTSENSE_EN to build the active-sensing timeout that drives all_notes_off.
module midi_msg_decoder #(
  parameter int MIDI_CH        = 0,
  parameter int OMNI           = 1,
  parameter int ASENSE_TIMEOUT = 7500000
) (
  input  logic       CLOCK_25,
  input  logic       iRST_N,
  input  logic       byteready,
  input  logic [7:0] midibyte,
  output logic       msg_valid,
  input  logic       msg_ready,
  output logic [7:0] msg_status,
  output logic [6:0] msg_data1,
  output logic [6:0] msg_data2,
  output logic       overflow,
  output logic       all_notes_off
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2
  } state_t;

  localparam logic [3:0] CH_SEL = 4'(MIDI_CH);

  logic       byteready_meta_r;
  logic       byteready_sync_r;
  logic       byteready_prev_r;
  logic       byte_stb_s;
  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] run_status_r;
  logic [7:0] run_status_nxt_s;
  logic [6:0] d1_r;
  logic [6:0] d1_nxt_s;
  logic       msg_done_s;
  logic [7:0] done_status_s;
  logic [6:0] done_d1_s;
  logic [6:0] done_d2_s;
  logic [7:0] pres_status_s;
  logic [6:0] pres_d2_s;
  logic       chan_ok_s;
  logic       accept_s;
  logic       load_s;

  // Bring byteready into the CLOCK_25 domain and keep the previous level for edge detection
  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      byteready_meta_r <= 1'b0;
      byteready_sync_r <= 1'b0;
      byteready_prev_r <= 1'b0;
    end else begin
      byteready_meta_r <= byteready;
      byteready_sync_r <= byteready_meta_r;
      byteready_prev_r <= byteready_sync_r;
    end
  end

  assign byte_stb_s = byteready_sync_r & ~byteready_prev_r;

  // Parser state register: FSM state, running status and first data byte
  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r      <= IDLE;
      run_status_r <= 8'h00;
      d1_r         <= 7'h00;
    end else begin
      state_r      <= state_nxt_s;
      run_status_r <= run_status_nxt_s;
      d1_r         <= d1_nxt_s;
    end
  end

  // Byte classification, next state and message completion
  always_comb begin
    state_nxt_s      = state_r;
    run_status_nxt_s = run_status_r;
    d1_nxt_s         = d1_r;
    msg_done_s       = 1'b0;
    done_status_s    = run_status_r;
    done_d1_s        = d1_r;
    done_d2_s        = 7'h00;
    if (byte_stb_s) begin
      if (midibyte[7:3] == 5'b11111) begin
        // real-time bytes are transparent to the parser
        state_nxt_s = state_r;
      end else if (midibyte[7:4] == 4'hF) begin
        run_status_nxt_s = 8'h00;
        state_nxt_s      = IDLE;
      end else if (midibyte[7]) begin
        run_status_nxt_s = midibyte;
        state_nxt_s      = WAIT_D1;
      end else begin
        case (state_r)
          IDLE: begin
            state_nxt_s = IDLE;
          end
          WAIT_D1: begin
            d1_nxt_s  = midibyte[6:0];
            done_d1_s = midibyte[6:0];
            if (run_status_r[7:5] == 3'b110) begin
              msg_done_s  = 1'b1;
              state_nxt_s = WAIT_D1;
            end else begin
              state_nxt_s = WAIT_D2;
            end
          end
          WAIT_D2: begin
            done_d2_s   = midibyte[6:0];
            msg_done_s  = 1'b1;
            state_nxt_s = WAIT_D1;
          end
          default: begin
            state_nxt_s = IDLE;
          end
        endcase
      end
    end else begin
      msg_done_s = 1'b0;
    end
  end

  // Note-on with zero velocity is presented as note-off, velocity 64
  always_comb begin
    pres_status_s = done_status_s;
    pres_d2_s     = done_d2_s;
    if ((done_status_s[7:4] == 4'h9) && (done_d2_s == 7'h00)) begin
      pres_status_s = {4'h8, done_status_s[3:0]};
      pres_d2_s     = 7'h40;
    end else begin
      pres_d2_s = done_d2_s;
    end
  end

  assign chan_ok_s = (OMNI != 0) || (done_status_s[3:0] == CH_SEL);
  assign accept_s  = msg_done_s & chan_ok_s;
  assign load_s    = accept_s & (~msg_valid | msg_ready);

  // One-entry output slot with sticky overflow on a drop
  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      msg_valid  <= 1'b0;
      msg_status <= 8'h00;
      msg_data1  <= 7'h00;
      msg_data2  <= 7'h00;
      overflow   <= 1'b0;
    end else begin
      if (load_s) begin
        msg_valid  <= 1'b1;
        msg_status <= pres_status_s;
        msg_data1  <= done_d1_s;
        msg_data2  <= pres_d2_s;
      end else if (msg_valid && msg_ready) begin
        msg_valid <= 1'b0;
      end
      if (accept_s && !load_s) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef MIDI_ACTSENSE_EN
  localparam logic [22:0] ASENSE_LOAD = 23'(ASENSE_TIMEOUT);

  logic        asense_armed_r;
  logic [22:0] asense_cnt_r;
  logic        notes_off_r;

  // Active-sensing watchdog: any byte while armed restarts the timeout
  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      asense_armed_r <= 1'b0;
      asense_cnt_r   <= 23'd0;
      notes_off_r    <= 1'b0;
    end else begin
      notes_off_r <= 1'b0;
      if (byte_stb_s && (asense_armed_r || (midibyte == 8'hFE))) begin
        asense_armed_r <= 1'b1;
        asense_cnt_r   <= ASENSE_LOAD;
      end else if (asense_armed_r) begin
        if (asense_cnt_r == 23'd0) begin
          asense_armed_r <= 1'b0;
          notes_off_r    <= 1'b1;
        end else begin
          asense_cnt_r <= asense_cnt_r - 23'd1;
        end
      end
    end
  end

  assign all_notes_off = notes_off_r;
`else
  assign all_notes_off = 1'b0;
`endif

endmodule
